// File: rtl/cmac_tx_gate_if.sv
// AXI-Stream bundle used on both sides of the CMAC TX gate.
// The slave view omits tuser because the user stream has no error marking.
interface cmac_tx_gate_if #(
  parameter int unsigned DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/cmac_tx_gate.sv
// Gates the user TX AXI-Stream into the CMAC on debounced PCS alignment, on packet boundaries.
// Define CMAC_TX_GATE_STATS_EN to build the drop/abort/link-down statistics counters.
module cmac_tx_gate #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned LINK_UP_CYCLES = 1024,
  parameter int unsigned ABORT_TIMEOUT  = 64
) (
  input  logic                  tx_clk,
  input  logic                  tx_reset,
  input  logic                  stat_rx_aligned,
  cmac_tx_gate_if.slave         axis_in,
  cmac_tx_gate_if.master        axis_out,
  output logic                  link_up,
  output logic [31:0]           drop_packets,
  output logic [31:0]           abort_packets,
  output logic [31:0]           link_down_events
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;
  localparam int unsigned UpW       = $clog2(LINK_UP_CYCLES + 1);
  localparam int unsigned AbortW    = $clog2(ABORT_TIMEOUT + 1);

  typedef enum logic [1:0] {StDrop, StPass, StAbort} state_e;

  state_e            state_q, state_d;
  logic [3:0]        sync_q;
  logic [UpW-1:0]    up_cnt_q;
  logic [AbortW-1:0] abort_cnt_q, abort_cnt_d;
  logic              in_packet_q;
  logic              in_accept;
  logic              aligned_sync;
  logic              up_done;
  logic              pass_open;

  assign aligned_sync = sync_q[3];
  assign up_done      = (up_cnt_q == UpW'(LINK_UP_CYCLES));
  // No down-debounce: loss of synchronized alignment drops link_up immediately.
  assign link_up      = aligned_sync & up_done;
  assign in_accept    = axis_in.tvalid & axis_in.tready;

  always_comb begin
    state_d         = state_q;
    abort_cnt_d     = '0;
    pass_open       = in_packet_q;
    axis_in.tready  = 1'b0;
    axis_out.tdata  = axis_in.tdata;
    axis_out.tkeep  = axis_in.tkeep;
    axis_out.tlast  = axis_in.tlast;
    axis_out.tuser  = 1'b0;
    axis_out.tvalid = 1'b0;
    unique case (state_q)
      StDrop: begin
        axis_in.tready = 1'b1;
        if (link_up && !in_packet_q && !axis_in.tvalid) state_d = StPass;
      end
      StPass: begin
        axis_in.tready  = axis_out.tready;
        axis_out.tvalid = axis_in.tvalid;
        // A beat accepted this cycle decides whether the packet is still open.
        if (axis_in.tvalid && axis_out.tready) pass_open = ~axis_in.tlast;
        if (!link_up) state_d = pass_open ? StAbort : StDrop;
      end
      StAbort: begin
        axis_out.tdata  = {DATA_WIDTH{1'b0}};
        axis_out.tkeep  = {KeepWidth{1'b1}};
        axis_out.tlast  = 1'b1;
        axis_out.tuser  = 1'b1;
        axis_out.tvalid = 1'b1;
        if (axis_out.tready || abort_cnt_q == AbortW'(ABORT_TIMEOUT - 1)) begin
          state_d = StDrop;
        end else begin
          abort_cnt_d = abort_cnt_q + AbortW'(1);
        end
      end
      default: state_d = StDrop;
    endcase
    if (tx_reset) begin
      axis_in.tready  = 1'b0;
      axis_out.tvalid = 1'b0;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      state_q     <= StDrop;
      sync_q      <= '0;
      up_cnt_q    <= '0;
      abort_cnt_q <= '0;
      in_packet_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[2:0], stat_rx_aligned};
      abort_cnt_q <= abort_cnt_d;
      if (!aligned_sync) begin
        up_cnt_q <= '0;
      end else if (!up_done) begin
        up_cnt_q <= up_cnt_q + UpW'(1);
      end
      if (in_accept) in_packet_q <= ~axis_in.tlast;
    end
  end

`ifdef CMAC_TX_GATE_STATS_EN
  logic [31:0] drop_q, abort_q, down_q;
  logic        link_up_prev_q;
  logic        drop_inc, abort_inc, down_inc;

  assign drop_inc  = (state_q == StDrop) & in_accept & axis_in.tlast;
  assign abort_inc = (state_q == StPass) & (state_d == StAbort);
  assign down_inc  = link_up_prev_q & ~link_up;

  always_ff @(posedge tx_clk or posedge tx_reset) begin
    if (tx_reset) begin
      drop_q         <= '0;
      abort_q        <= '0;
      down_q         <= '0;
      link_up_prev_q <= 1'b0;
    end else begin
      link_up_prev_q <= link_up;
      if (drop_inc)  drop_q  <= drop_q + 32'd1;
      if (abort_inc) abort_q <= abort_q + 32'd1;
      if (down_inc)  down_q  <= down_q + 32'd1;
    end
  end

  assign drop_packets     = drop_q;
  assign abort_packets    = abort_q;
  assign link_down_events = down_q;
`else
  assign drop_packets     = 32'd0;
  assign abort_packets    = 32'd0;
  assign link_down_events = 32'd0;
`endif

endmodule
